tdc_hw_accum: RTL and testbench
===============================

TDC_HW_ACCUM -- requirements
Module: tdc_hw_accum

Interface
REQ-001 SHALL have parameter HW_W, default 7, meaning width of the TDC hamming-weight sample.
REQ-002 SHALL have parameter LOG2_NS, default 4, meaning log2 of the number of samples per batch (NS = 2^LOG2_NS).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 SHALL have port en  input  1  block enable; when low, no sample is accepted and the FSM holds its state.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a batch.
REQ-007 SHALL have port hw_in  input  HW_W  hamming-weight sample from the TDC, already synchronous to clk.
REQ-008 SHALL have port val_in  input  1  hw_in is valid this cycle.
REQ-009 SHALL have port res_rdy  input  1  consumer can take the result.
REQ-010 SHALL have port res_val  output  1  result valid.
REQ-011 SHALL have port res_sum  output  HW_W+LOG2_NS  batch sum.
REQ-012 SHALL have port res_avg  output  HW_W  batch mean.
REQ-013 SHALL have port res_min  output  HW_W  batch minimum.
REQ-014 SHALL have port res_max  output  HW_W  batch maximum.
REQ-015 SHALL have port busy  output  1  high in the ACCUM state.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM and DONE.
REQ-017 IDLE: when start=1 and en=1, the FSM SHALL go to ACCUM and clear the sum, the sample count and min/max (min = all-ones, max = 0); val_in in that same cycle SHALL NOT be counted.
REQ-018 ACCUM: each cycle with en=1 and val_in=1 SHALL add hw_in to the sum, increment the count and update min/max.
REQ-019 ACCUM: the sample that brings the count to NS SHALL move the FSM to DONE; res_val SHALL assert on the next clock edge (latency 1 cycle after the last accepted sample).
REQ-020 ACCUM: start SHALL be ignored.
REQ-021 The sum SHALL be HW_W+LOG2_NS bits wide, so it never overflows.
REQ-022 The sample count SHALL wrap only through the transition to DONE.
REQ-023 res_avg SHALL equal res_sum >> LOG2_NS, truncated with no rounding.
REQ-024 DONE: res_val=1; res_sum, res_avg, res_min and res_max SHALL stay registered and stable until the handshake; val_in SHALL be ignored.
REQ-025 DONE with res_val=1 and res_rdy=1: if start=1 in the same cycle, the FSM SHALL go to ACCUM and clear the accumulators; otherwise it SHALL go to IDLE.
REQ-026 After the handshake, the result outputs SHALL keep their last values until the next batch completes.
REQ-027 en=0 SHALL freeze the FSM, the counters and the accumulators in every state.
REQ-028 While en=0 in DONE, res_val SHALL stay high.

Reset
REQ-029 rst_n=0 SHALL asynchronously force IDLE with res_val=0, busy=0 and count=0.
REQ-030 On reset, res_sum, res_avg, res_min and res_max SHALL go to 0.
REQ-031 Reset asserted during ACCUM or DONE SHALL discard the partial batch, and no res_val SHALL follow the release of reset.

Configuration
REQ-032 Macro TDC_HW_MINMAX_EN: when defined, min/max tracking SHALL be compiled in as described above.
REQ-033 When TDC_HW_MINMAX_EN is undefined, res_min and res_max SHALL remain on the interface, tied to 0, with no min/max registers.

Verification
REQ-034 The bench SHALL cover: LOG2_NS=2, start, then hw_in 10,20,30,40 on consecutive val_in cycles -> res_val on the cycle after the 4th sample, res_sum=100, res_avg=25, res_min=10, res_max=40.
REQ-035 The bench SHALL cover: LOG2_NS=4, 16 samples of 64 -> res_sum=1024 with no overflow, res_avg=64, res_min=res_max=64.
REQ-036 The bench SHALL cover: res_rdy held low for 5 cycles in DONE while val_in toggles -> outputs unchanged and res_val held; res_rdy=1 -> FSM to IDLE on the next edge.
REQ-037 The bench SHALL cover: start pulsed during ACCUM after 2 of 4 samples, and en dropped for 3 cycles carrying val_in=1 -> start ignored, dropped samples not counted, the batch completes after 4 accepted samples.
REQ-038 The bench SHALL cover: rst_n low after 3 of 4 samples -> all outputs 0, state IDLE; a new start plus 4 samples of 7 -> res_sum=28, res_avg=7.
REQ-039 The bench SHALL cover: TDC_HW_MINMAX_EN undefined, samples 5,9,1,3 -> res_min=res_max=0, res_sum=18, res_avg=4.

Source files
------------

// File: rtl/tdc_hw_accum.sv
// tdc_hw_accum: accumulates batches of 2^LOG2_NS TDC hamming-weight samples
// and reports their sum, mean and (optionally) minimum/maximum.
// Optional build macro: TDC_HW_MINMAX_EN adds min/max tracking; when it is
// undefined, res_min/res_max are tied to 0 and no min/max registers exist.
module tdc_hw_accum #(
   parameter int HW_W    = 7,
   parameter int LOG2_NS = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    start,
   input  logic [HW_W-1:0]         hw_in,
   input  logic                    val_in,
   input  logic                    res_rdy,
   output logic                    res_val,
   output logic [HW_W+LOG2_NS-1:0] res_sum,
   output logic [HW_W-1:0]         res_avg,
   output logic [HW_W-1:0]         res_min,
   output logic [HW_W-1:0]         res_max,
   output logic                    busy
);

   localparam int unsigned SW = HW_W + LOG2_NS;
   localparam int unsigned CW = LOG2_NS;
   localparam int unsigned NS = 1 << LOG2_NS;

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   sum_acc;
   logic [SW-1:0]   sum_nxt;
   logic            accept_c;
   logic            last_c;
   logic            clear_c;

   assign sum_nxt = sum_acc + SW'(hw_in);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and per-cycle datapath controls
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      last_c    = 1'b0;
      clear_c   = 1'b0;
      case (state)
         IDLE: begin
            if (en && start) begin
               clear_c   = 1'b1;
               state_nxt = ACCUM;
            end
         end
         ACCUM: begin
            accept_c = en && val_in;
            last_c   = accept_c && (cnt == CW'(NS - 1));
            if (last_c) state_nxt = DONE;
         end
         DONE: begin
            if (en && res_rdy) begin
               clear_c   = start;
               state_nxt = start ? ACCUM : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Accumulators, sample count, status flags and sum/avg result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         sum_acc <= '0;
         res_sum <= '0;
         res_avg <= '0;
         res_val <= 1'b0;
         busy    <= 1'b0;
      end else begin
         res_val <= (state_nxt == DONE);
         busy    <= (state_nxt == ACCUM);
         if (clear_c) begin
            cnt     <= '0;
            sum_acc <= '0;
         end else if (accept_c) begin
            cnt     <= cnt + CW'(1);
            sum_acc <= sum_nxt;
         end
         if (last_c) begin
            res_sum <= sum_nxt;
            res_avg <= HW_W'(sum_nxt >> LOG2_NS);
         end
      end
   end

`ifdef TDC_HW_MINMAX_EN
   logic [HW_W-1:0] min_acc, max_acc;
   logic [HW_W-1:0] min_nxt, max_nxt;

   assign min_nxt = (hw_in < min_acc) ? hw_in : min_acc;
   assign max_nxt = (hw_in > max_acc) ? hw_in : max_acc;

   // Running min/max and their result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_acc <= '1;
         max_acc <= '0;
         res_min <= '0;
         res_max <= '0;
      end else begin
         if (clear_c) begin
            min_acc <= '1;
            max_acc <= '0;
         end else if (accept_c) begin
            min_acc <= min_nxt;
            max_acc <= max_nxt;
         end
         if (last_c) begin
            res_min <= min_nxt;
            res_max <= max_nxt;
         end
      end
   end
`else
   assign res_min = '0;
   assign res_max = '0;
`endif

endmodule

// File: tb/tb_tdc_hw_accum.sv
// Directed self-checking bench for tdc_hw_accum: one LOG2_NS=2 instance and
// one LOG2_NS=4 instance. Min/max expectations follow TDC_HW_MINMAX_EN.
module tb_tdc_hw_accum;

`ifdef TDC_HW_MINMAX_EN
   localparam bit MM = 1'b1;
`else
   localparam bit MM = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   // LOG2_NS = 2 instance
   logic       en2 = 1'b0, start2 = 1'b0, val2 = 1'b0, rdy2 = 1'b0;
   logic [6:0] hw2 = '0;
   logic       res_val2, busy2;
   logic [8:0] sum2;
   logic [6:0] avg2, min2, max2;

   // LOG2_NS = 4 instance
   logic        en4 = 1'b0, start4 = 1'b0, val4 = 1'b0, rdy4 = 1'b0;
   logic [6:0]  hw4 = '0;
   logic        res_val4, busy4;
   logic [10:0] sum4;
   logic [6:0]  avg4, min4, max4;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   tdc_hw_accum #(.HW_W(7), .LOG2_NS(2)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .start(start2), .hw_in(hw2),
      .val_in(val2), .res_rdy(rdy2), .res_val(res_val2), .res_sum(sum2),
      .res_avg(avg2), .res_min(min2), .res_max(max2), .busy(busy2)
   );

   tdc_hw_accum #(.HW_W(7), .LOG2_NS(4)) u4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .start(start4), .hw_in(hw4),
      .val_in(val4), .res_rdy(rdy4), .res_val(res_val4), .res_sum(sum4),
      .res_avg(avg4), .res_min(min4), .res_max(max4), .busy(busy4)
   );

   function automatic int mm(input int v);
      return MM ? v : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_res2(input string tag, input int v, input int s, input int a,
                           input int mn, input int mx);
      chk({tag, ".val"}, 32'(res_val2), 32'(v));
      chk({tag, ".sum"}, 32'(sum2), 32'(s));
      chk({tag, ".avg"}, 32'(avg2), 32'(a));
      chk({tag, ".min"}, 32'(min2), 32'(mm(mn)));
      chk({tag, ".max"}, 32'(max2), 32'(mm(mx)));
   endtask

   initial begin
      // Reset state
      #2 rst_n = 1'b0;
      cyc(1);
      chk_res2("rst", 0, 0, 0, 0, 0);
      chk("rst.busy", 32'(busy2), 0);
      chk("rst4.val", 32'(res_val4), 0);
      rst_n = 1'b1;
      en2 = 1'b1;
      cyc(1);

      // Basic batch: 10,20,30,40
      start2 = 1'b1; val2 = 1'b1; hw2 = 7'd99;   // same-cycle sample ignored
      cyc(1);
      chk("b1.busy", 32'(busy2), 1);
      start2 = 1'b0;
      hw2 = 7'd10; cyc(1);
      hw2 = 7'd20; cyc(1);
      hw2 = 7'd30; cyc(1);
      chk("b1.val_early", 32'(res_val2), 0);
      hw2 = 7'd40; cyc(1);
      val2 = 1'b0;
      chk_res2("b1", 1, 100, 25, 10, 40);
      chk("b1.busy_done", 32'(busy2), 0);

      // Hold in DONE with res_rdy low while val_in toggles
      hw2 = 7'd5;
      for (int i = 0; i < 5; i++) begin
         val2 = ~val2;
         cyc(1);
         chk_res2("hold", 1, 100, 25, 10, 40);
      end
      val2 = 1'b0;
      rdy2 = 1'b1;
      cyc(1);
      rdy2 = 1'b0;
      chk_res2("hs", 0, 100, 25, 10, 40);
      chk("hs.busy", 32'(busy2), 0);

      // start during ACCUM ignored, en low drops samples
      start2 = 1'b1; cyc(1); start2 = 1'b0;
      val2 = 1'b1;
      hw2 = 7'd1; cyc(1);
      hw2 = 7'd2; cyc(1);
      start2 = 1'b1; hw2 = 7'd3; cyc(1); start2 = 1'b0;
      chk("se.val3", 32'(res_val2), 0);
      en2 = 1'b0; hw2 = 7'd100;
      cyc(3);
      chk("se.busy_frozen", 32'(busy2), 1);
      chk("se.val_frozen", 32'(res_val2), 0);
      en2 = 1'b1; hw2 = 7'd4; cyc(1);
      val2 = 1'b0;
      chk_res2("se", 1, 10, 2, 1, 4);

      // en low in DONE keeps res_val high, handshake ignored
      en2 = 1'b0; rdy2 = 1'b1; cyc(2);
      chk("en0.val", 32'(res_val2), 1);

      // Handshake with start goes straight back to ACCUM; outputs retained
      en2 = 1'b1; start2 = 1'b1; cyc(1);
      start2 = 1'b0; rdy2 = 1'b0;
      chk("rs.busy", 32'(busy2), 1);
      chk_res2("rs", 0, 10, 2, 1, 4);

      // Reset mid-batch after 3 of 4 samples
      val2 = 1'b1; hw2 = 7'd7;
      cyc(3);
      val2 = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_res2("mrst", 0, 0, 0, 0, 0);
      chk("mrst.busy", 32'(busy2), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      chk("mrst.noval", 32'(res_val2), 0);
      chk("mrst.idle", 32'(busy2), 0);
      start2 = 1'b1; cyc(1); start2 = 1'b0;
      val2 = 1'b1; hw2 = 7'd7;
      cyc(4);
      val2 = 1'b0;
      chk_res2("r7", 1, 28, 7, 7, 7);
      rdy2 = 1'b1; cyc(1); rdy2 = 1'b0;

      // Samples 5,9,1,3
      start2 = 1'b1; cyc(1); start2 = 1'b0;
      val2 = 1'b1;
      hw2 = 7'd5; cyc(1);
      hw2 = 7'd9; cyc(1);
      hw2 = 7'd1; cyc(1);
      hw2 = 7'd3; cyc(1);
      val2 = 1'b0;
      chk_res2("m4", 1, 18, 4, 1, 9);

      // 16 samples of 64 on the LOG2_NS=4 instance
      en4 = 1'b1; start4 = 1'b1; cyc(1); start4 = 1'b0;
      chk("n16.busy", 32'(busy4), 1);
      val4 = 1'b1; hw4 = 7'd64;
      cyc(15);
      chk("n16.val_early", 32'(res_val4), 0);
      cyc(1);
      val4 = 1'b0;
      chk("n16.val", 32'(res_val4), 1);
      chk("n16.sum", 32'(sum4), 1024);
      chk("n16.avg", 32'(avg4), 64);
      chk("n16.min", 32'(min4), 32'(mm(64)));
      chk("n16.max", 32'(max4), 32'(mm(64)));
      rdy4 = 1'b1; cyc(1); rdy4 = 1'b0;
      chk("n16.hs", 32'(res_val4), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
